alu_pair_sequencer: RTL and testbench

- Sequences 16-bit arithmetic (ADD HL,rr; INC rr; DEC rr; ADD SP,e8) through the 8-bit ALU as two back-to-back byte passes with carry chaining.
- Sits directly upstream of the ALU: drives the ALU's operand and control inputs, and captures the ALU result and carries each pass.
- Returns the assembled 16-bit result plus Game Boy flag values and a flag write-mask to the register-file/flag writeback.

---
 rtl/alu_pair_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_pair_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pair_sequencer.sv
// Sequences 16-bit register-pair arithmetic through an 8-bit ALU as a low-byte
// pass followed by a high-byte pass. The carry from the low pass is chained
// into the high pass. The block returns the assembled word and the flag values
// and write mask that the flag writeback expects.
module alu_pair_sequencer #(
    parameter int                      DATA_WIDTH   = 8,
    parameter int                      OPCODE_WIDTH = 3,
    parameter logic [OPCODE_WIDTH-1:0] ALU_ADD      = 3'b000,
    parameter logic [OPCODE_WIDTH-1:0] ALU_ADC      = 3'b001,
    parameter logic [OPCODE_WIDTH-1:0] ALU_SUB      = 3'b010,
    parameter logic [OPCODE_WIDTH-1:0] ALU_SBC      = 3'b011
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [1:0]                i_op,
    input  logic [2*DATA_WIDTH-1:0]   i_operand_A,
    input  logic [2*DATA_WIDTH-1:0]   i_operand_B,
    output logic [DATA_WIDTH-1:0]     o_alu_A,
    output logic [DATA_WIDTH-1:0]     o_alu_B,
    output logic [OPCODE_WIDTH-1:0]   o_alu_control,
    output logic                      o_alu_carry_in,
    input  logic [DATA_WIDTH-1:0]     i_alu_data,
    input  logic                      i_alu_carry,
    input  logic                      i_alu_half_carry,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [2*DATA_WIDTH-1:0]   o_result,
    output logic [3:0]                o_flags,
    output logic [3:0]                o_flags_mask
);

    localparam int WORD_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOW  = 2'b01,
        S_HIGH = 2'b10,
        S_DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD16  = 2'b00,
        OP_INC16  = 2'b01,
        OP_DEC16  = 2'b10,
        OP_ADDSPE = 2'b11
    } op_t;

    state_t                  r_state;
    state_t                  w_next_state;
    op_t                     r_op;
    logic [WORD_WIDTH-1:0]   r_a;
    logic [WORD_WIDTH-1:0]   r_b;
    logic [WORD_WIDTH-1:0]   r_result;
    logic                    r_c_lo;
    logic                    r_h_lo;
    logic                    r_c_hi;
    logic                    r_h_hi;
    logic                    r_flags_valid;
    logic                    w_accept;
    logic [WORD_WIDTH-1:0]   w_b_eff;

    assign w_accept = (r_state == S_IDLE) && i_start;

    // Build the effective second operand. INC and DEC both step by one, with
    // DEC choosing subtraction later. ADD SP,e8 sign-extends the displacement
    // byte.
    always_comb begin
        w_b_eff = i_operand_B;
        case (i_op)
            OP_ADD16:  w_b_eff = i_operand_B;
            OP_INC16:  w_b_eff = WORD_WIDTH'(1);
            OP_DEC16:  w_b_eff = WORD_WIDTH'(1);
            default:   w_b_eff = {{DATA_WIDTH{i_operand_B[DATA_WIDTH-1]}},
                                  i_operand_B[DATA_WIDTH-1:0]};
        endcase
    end

    // State register. Reset aborts any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fixed four-step walk. A start request only matters while idle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = i_start ? S_LOW : S_IDLE;
            S_LOW:   w_next_state = S_HIGH;
            S_HIGH:  w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Latch operands on acceptance, then capture each byte pass from the ALU.
    // The flag-valid bit drops on a new start so stale flags are never shown
    // against a new operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op          <= OP_ADD16;
            r_a           <= '0;
            r_b           <= '0;
            r_result      <= '0;
            r_c_lo        <= 1'b0;
            r_h_lo        <= 1'b0;
            r_c_hi        <= 1'b0;
            r_h_hi        <= 1'b0;
            r_flags_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op          <= op_t'(i_op);
                r_a           <= i_operand_A;
                r_b           <= w_b_eff;
                r_flags_valid <= 1'b0;
            end
            if (r_state == S_LOW) begin
                r_result[DATA_WIDTH-1:0] <= i_alu_data;
                r_c_lo                   <= i_alu_carry;
                r_h_lo                   <= i_alu_half_carry;
            end
            if (r_state == S_HIGH) begin
                r_result[WORD_WIDTH-1:DATA_WIDTH] <= i_alu_data;
                r_c_hi                            <= i_alu_carry;
                r_h_hi                            <= i_alu_half_carry;
                r_flags_valid                     <= 1'b1;
            end
        end
    end

    // Drive the ALU for the current byte pass. Outside the two passes, the ALU
    // sees a harmless ADD of zeros.
    always_comb begin
        o_alu_A        = '0;
        o_alu_B        = '0;
        o_alu_control  = ALU_ADD;
        o_alu_carry_in = 1'b0;
        case (r_state)
            S_LOW: begin
                o_alu_A       = r_a[DATA_WIDTH-1:0];
                o_alu_B       = r_b[DATA_WIDTH-1:0];
                o_alu_control = (r_op == OP_DEC16) ? ALU_SUB : ALU_ADD;
            end
            S_HIGH: begin
                o_alu_A        = r_a[WORD_WIDTH-1:DATA_WIDTH];
                o_alu_B        = r_b[WORD_WIDTH-1:DATA_WIDTH];
                o_alu_control  = (r_op == OP_DEC16) ? ALU_SBC : ALU_ADC;
                o_alu_carry_in = r_c_lo;
            end
            default: ;
        endcase
    end

    // Flags come only from registers, so they are stable from DONE onward.
    // ADD HL uses the high pass carries. ADD SP,e8 uses the low pass carries.
    // 16-bit INC and DEC leave the flags untouched.
    always_comb begin
        o_flags      = 4'b0000;
        o_flags_mask = 4'b0000;
        if (r_flags_valid) begin
            case (r_op)
                OP_ADD16: begin
                    o_flags      = {1'b0, 1'b0, r_h_hi, r_c_hi};
                    o_flags_mask = 4'b0111;
                end
                OP_ADDSPE: begin
                    o_flags      = {1'b0, 1'b0, r_h_lo, r_c_lo};
                    o_flags_mask = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = (r_state == S_DONE);
    assign o_result = r_result;

endmodule

// File: tb/tb_alu_pair_sequencer.sv
// Scoreboard bench for alu_pair_sequencer. A behavioural byte ALU closes the
// loop around the sequencer. Expected words and flags are queued when each
// start is issued. A monitor checks them on every done pulse.
module tb_alu_pair_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] operandA;
    logic [15:0] operandB;
    logic [7:0]  aluA;
    logic [7:0]  aluB;
    logic [2:0]  aluControl;
    logic        aluCarryIn;
    logic [7:0]  aluData;
    logic        aluCarry;
    logic        aluHalfCarry;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags;
    logic [3:0]  flagsMask;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        logic [3:0]  mask;
        int          issue;
    } exp_t;

    exp_t sbQ[$];
    int   assertions    = 0;
    int   failures      = 0;
    int   cycleCount    = 0;
    int   doneCount     = 0;
    int   expectedDones = 0;

    alu_pair_sequencer dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_op             (op),
        .i_operand_A      (operandA),
        .i_operand_B      (operandB),
        .o_alu_A          (aluA),
        .o_alu_B          (aluB),
        .o_alu_control    (aluControl),
        .o_alu_carry_in   (aluCarryIn),
        .i_alu_data       (aluData),
        .i_alu_carry      (aluCarry),
        .i_alu_half_carry (aluHalfCarry),
        .o_busy           (busy),
        .o_done           (done),
        .o_result         (result),
        .o_flags          (flags),
        .o_flags_mask     (flagsMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Byte ALU model: add or subtract with optional carry-in, reporting the
    // carry or borrow out of bit 7 and bit 3.
    always_comb begin
        logic [8:0] s;
        logic [4:0] hs;
        logic       cin;
        cin = aluControl[0] ? aluCarryIn : 1'b0;
        if (aluControl[1]) begin
            s  = {1'b0, aluA} - {1'b0, aluB} - {8'b0, cin};
            hs = {1'b0, aluA[3:0]} - {1'b0, aluB[3:0]} - {4'b0, cin};
        end else begin
            s  = {1'b0, aluA} + {1'b0, aluB} + {8'b0, cin};
            hs = {1'b0, aluA[3:0]} + {1'b0, aluB[3:0]} + {4'b0, cin};
        end
        aluData      = s[7:0];
        aluCarry     = s[8];
        aluHalfCarry = hs[4];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] newOp, input logic [15:0] a,
                                 input logic [15:0] b, input bit expectDone,
                                 input logic [15:0] expRes, input logic [3:0] expFlags,
                                 input logic [3:0] expMask);
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        op       = newOp;
        operandA = a;
        operandB = b;
        if (expectDone) begin
            e.res   = expRes;
            e.flags = expFlags;
            e.mask  = expMask;
            e.issue = cycleCount;
            sbQ.push_back(e);
            expectedDones++;
        end
        @(negedge clk);
        start    = 1'b0;
        op       = 2'b00;
        operandA = 16'hDEAD;
        operandB = 16'hBEEF;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            assertions++;
            failures++;
            $display("[TB] FAIL waitIdle: busy still %0b after %0d cycles, expected 0", busy, n);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    // and must arrive three cycles after its start was accepted.
    always @(negedge clk) begin
        if (rst_n && done) begin
            doneCount++;
            if (sbQ.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpectedDone: got done with result %0h, expected no done", result);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("result",    32'(result),    32'(e.res));
                checkOutput("flags",     32'(flags),     32'(e.flags));
                checkOutput("flagsMask", 32'(flagsMask), 32'(e.mask));
                checkOutput("latency",   32'(cycleCount - e.issue), 32'd3);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        operandA = 16'h0000;
        operandB = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstBusy",    32'(busy),       32'd0);
        checkOutput("rstDone",    32'(done),       32'd0);
        checkOutput("rstResult",  32'(result),     32'd0);
        checkOutput("rstFlags",   32'(flags),      32'd0);
        checkOutput("rstMask",    32'(flagsMask),  32'd0);
        checkOutput("rstAluCtl",  32'(aluControl), 32'd0);
        rst_n = 1'b1;

        // ADD16 0x0FFF + 0x0001, with both byte passes inspected.
        applyStimulus(2'b00, 16'h0FFF, 16'h0001, 1'b1, 16'h1000, 4'b0010, 4'b0111);
        checkOutput("lowBusy",  32'(busy),       32'd1);
        checkOutput("lowA",     32'(aluA),       32'hFF);
        checkOutput("lowB",     32'(aluB),       32'h01);
        checkOutput("lowCtl",   32'(aluControl), 32'd0);
        checkOutput("lowCin",   32'(aluCarryIn), 32'd0);
        @(negedge clk);
        checkOutput("highA",    32'(aluA),       32'h0F);
        checkOutput("highB",    32'(aluB),       32'h00);
        checkOutput("highCtl",  32'(aluControl), 32'd1);
        checkOutput("highCin",  32'(aluCarryIn), 32'd1);
        waitIdle();

        applyStimulus(2'b00, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b0011, 4'b0111);
        waitIdle();
        applyStimulus(2'b01, 16'hFFFF, 16'hABCD, 1'b1, 16'h0000, 4'b0000, 4'b0000);
        waitIdle();

        // DEC16 0x0000 with a borrow chained into the high pass.
        applyStimulus(2'b10, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, 4'b0000, 4'b0000);
        checkOutput("decLowCtl",  32'(aluControl), 32'd2);
        checkOutput("decLowB",    32'(aluB),       32'h01);
        @(negedge clk);
        checkOutput("decHighCtl", 32'(aluControl), 32'd3);
        checkOutput("decHighB",   32'(aluB),       32'h00);
        checkOutput("decHighCin", 32'(aluCarryIn), 32'd1);
        waitIdle();

        applyStimulus(2'b11, 16'hFFF8, 16'hFF08, 1'b1, 16'h0000, 4'b0011, 4'b1111);
        waitIdle();
        applyStimulus(2'b11, 16'h0005, 16'h00FE, 1'b1, 16'h0003, 4'b0011, 4'b1111);
        waitIdle();
        applyStimulus(2'b11, 16'h0100, 16'h0080, 1'b1, 16'h0080, 4'b0000, 4'b1111);
        waitIdle();

        // Start re-pulsed during LOW and HIGH with other operands is ignored.
        applyStimulus(2'b00, 16'h1234, 16'h1111, 1'b1, 16'h2345, 4'b0000, 4'b0111);
        start    = 1'b1;
        op       = 2'b10;
        operandA = 16'hFFFF;
        operandB = 16'hFFFF;
        @(negedge clk);
        checkOutput("busyHighA", 32'(aluA), 32'h12);
        op       = 2'b01;
        operandA = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        waitIdle();

        // Reset during HIGH aborts the operation without a done pulse.
        applyStimulus(2'b00, 16'h4444, 16'h3333, 1'b0, 16'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusy",   32'(busy),       32'd0);
        checkOutput("abortDone",   32'(done),       32'd0);
        checkOutput("abortResult", 32'(result),     32'd0);
        checkOutput("abortFlags",  32'(flags),      32'd0);
        checkOutput("abortMask",   32'(flagsMask),  32'd0);
        checkOutput("abortAluA",   32'(aluA),       32'd0);
        checkOutput("abortAluB",   32'(aluB),       32'd0);
        checkOutput("abortCin",    32'(aluCarryIn), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // A normal operation after reset: ADD16 0x8A23 + 0x8605.
        applyStimulus(2'b00, 16'h8A23, 16'h8605, 1'b1, 16'h1028, 4'b0011, 4'b0111);
        waitIdle();
        repeat (3) @(negedge clk);

        checkOutput("doneCount",  32'(doneCount),  32'(expectedDones));
        checkOutput("sbDrained",  32'(sbQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
